// File: rtl/reg_file_2r1w_pkg.sv
// Shared constants and types for the RV32I integer register file.
package reg_file_2r1w_pkg;
    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int AW    = 5;
    localparam int CNT_W = 16;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef logic [AW-1:0] reg_addr_t;

    localparam reg_addr_t ZERO_REG = 5'd0;
endpackage

// File: rtl/reg_file_2r1w_if.sv
// Read/write port bundle between the pipeline (master) and the register file (slave).
interface reg_file_2r1w_if;
    import reg_file_2r1w_pkg::*;

    reg_addr_t              rs1_addr;
    reg_addr_t              rs2_addr;
    reg_addr_t              rd_addr;
    logic [XLEN-1:0]        wr_data;
    logic                   reg_write;
    reg_addr_t              dbg_addr;
    logic [XLEN-1:0]        rs1_data;
    logic [XLEN-1:0]        rs2_data;
    logic [XLEN-1:0]        dbg_data;
    logic [CNT_W-1:0]       wr_count;

    modport master (
        output rs1_addr, rs2_addr, rd_addr, wr_data, reg_write, dbg_addr,
        input  rs1_data, rs2_data, dbg_data, wr_count
    );

    modport slave (
        input  rs1_addr, rs2_addr, rd_addr, wr_data, reg_write, dbg_addr,
        output rs1_data, rs2_data, dbg_data, wr_count
    );
endinterface

// File: rtl/reg_file_2r1w_dec.sv
// 5-to-32 write-enable decoder: one-hot load vector gated by en.
module reg_file_2r1w_dec
    import reg_file_2r1w_pkg::*;
(
    input  logic             en,
    input  reg_addr_t        addr,
    output logic [NREGS-1:0] load
);

    always_comb begin
        load       = '0;
        load[addr] = en;
    end

endmodule

// File: rtl/reg_file_2r1w.sv
// 32 x 32-bit register file: two bypassable read ports, one debug read port,
// one write port, and a saturating count of committed non-x0 writes.
module reg_file_2r1w
    import reg_file_2r1w_pkg::*;
#(
    parameter bit BYPASS_EN = 1'b1
) (
    input  logic           clk,
    input  logic           rst,
    reg_file_2r1w_if.slave bus
);

    logic [XLEN-1:0]  regs_q [NREGS];
    logic [XLEN-1:0]  regs_d [NREGS];
    logic [CNT_W-1:0] wr_count_q;
    logic [CNT_W-1:0] wr_count_d;
    logic [NREGS-1:0] load;
    logic             byp_ok;
    logic             hit1;
    logic             hit2;

    reg_file_2r1w_dec u_dec (
        .en   (bus.reg_write & ~rst),
        .addr (bus.rd_addr),
        .load (load)
    );

    always_comb begin
        for (int i = 0; i < NREGS; i++) begin
            regs_d[i] = regs_q[i];
            if (load[i]) begin
                regs_d[i] = bus.wr_data;
            end
        end
        // x0 is hardwired; its load bit is deliberately dropped here.
        regs_d[0] = '0;

        wr_count_d = wr_count_q;
        if (|load[NREGS-1:1] && wr_count_q != CNT_MAX) begin
            wr_count_d = wr_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
            wr_count_q <= '0;
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
            wr_count_q <= wr_count_d;
        end
    end

    always_comb begin
        byp_ok = BYPASS_EN && bus.reg_write && !rst && (bus.rd_addr != ZERO_REG);
        hit1   = byp_ok && (bus.rd_addr == bus.rs1_addr);
        hit2   = byp_ok && (bus.rd_addr == bus.rs2_addr);
    end

    assign bus.rs1_data = hit1 ? bus.wr_data :
                          (bus.rs1_addr == ZERO_REG) ? '0 : regs_q[bus.rs1_addr];
    assign bus.rs2_data = hit2 ? bus.wr_data :
                          (bus.rs2_addr == ZERO_REG) ? '0 : regs_q[bus.rs2_addr];
    assign bus.dbg_data = (bus.dbg_addr == ZERO_REG) ? '0 : regs_q[bus.dbg_addr];
    assign bus.wr_count = wr_count_q;

endmodule

// File: tb/tb_reg_file_2r1w.sv
// Directed self-checking bench for reg_file_2r1w.
module tb_reg_file_2r1w;
    import reg_file_2r1w_pkg::*;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    reg_file_2r1w_if bus ();

    reg_file_2r1w #(.BYPASS_EN(1'b1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle 1 time unit past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst           = 1'b1;
        bus.reg_write = 1'b0;
        bus.rd_addr   = 5'd0;
        bus.wr_data   = '0;
        bus.rs1_addr  = 5'd0;
        bus.rs2_addr  = 5'd0;
        bus.dbg_addr  = 5'd0;
        tick();
        rst          = 1'b0;
        bus.rs1_addr = 5'd7;
        bus.rs2_addr = 5'd31;
        bus.dbg_addr = 5'd15;
        #1;
        checks++;
        if (bus.rs1_data !== 32'h0) begin
            failures++;
            $display("FAIL reset_rs1 got=%h exp=%h", bus.rs1_data, 32'h0);
        end
        checks++;
        if (bus.rs2_data !== 32'h0) begin
            failures++;
            $display("FAIL reset_rs2 got=%h exp=%h", bus.rs2_data, 32'h0);
        end
        checks++;
        if (bus.dbg_data !== 32'h0) begin
            failures++;
            $display("FAIL reset_dbg got=%h exp=%h", bus.dbg_data, 32'h0);
        end
        checks++;
        if (bus.wr_count !== 16'd0) begin
            failures++;
            $display("FAIL reset_count got=%0d exp=%0d", bus.wr_count, 0);
        end
    endtask

    task automatic test_basic_write();
        bus.rd_addr   = 5'd5;
        bus.wr_data   = 32'hDEADBEEF;
        bus.reg_write = 1'b1;
        tick();
        bus.reg_write = 1'b0;
        bus.rs1_addr  = 5'd5;
        bus.dbg_addr  = 5'd5;
        #1;
        checks++;
        if (bus.rs1_data !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL basic_rs1 got=%h exp=%h", bus.rs1_data, 32'hDEADBEEF);
        end
        checks++;
        if (bus.dbg_data !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL basic_dbg got=%h exp=%h", bus.dbg_data, 32'hDEADBEEF);
        end
        checks++;
        if (bus.wr_count !== 16'd1) begin
            failures++;
            $display("FAIL basic_count got=%0d exp=%0d", bus.wr_count, 1);
        end
    endtask

    task automatic test_x0();
        bus.rd_addr   = 5'd0;
        bus.wr_data   = 32'hFFFFFFFF;
        bus.reg_write = 1'b1;
        bus.rs1_addr  = 5'd0;
        bus.dbg_addr  = 5'd0;
        #1;
        checks++;
        if (bus.rs1_data !== 32'h0) begin
            failures++;
            $display("FAIL x0_same_cycle got=%h exp=%h", bus.rs1_data, 32'h0);
        end
        tick();
        bus.reg_write = 1'b0;
        #1;
        checks++;
        if (bus.rs1_data !== 32'h0) begin
            failures++;
            $display("FAIL x0_next_cycle got=%h exp=%h", bus.rs1_data, 32'h0);
        end
        checks++;
        if (bus.dbg_data !== 32'h0) begin
            failures++;
            $display("FAIL x0_dbg got=%h exp=%h", bus.dbg_data, 32'h0);
        end
        checks++;
        if (bus.wr_count !== 16'd1) begin
            failures++;
            $display("FAIL x0_count got=%0d exp=%0d", bus.wr_count, 1);
        end
    endtask

    task automatic test_bypass();
        bus.rd_addr   = 5'd9;
        bus.wr_data   = 32'h1;
        bus.reg_write = 1'b1;
        tick();
        bus.wr_data  = 32'h2;
        bus.rs1_addr = 5'd9;
        bus.rs2_addr = 5'd9;
        bus.dbg_addr = 5'd9;
        #1;
        checks++;
        if (bus.rs1_data !== 32'h2) begin
            failures++;
            $display("FAIL bypass_rs1 got=%h exp=%h", bus.rs1_data, 32'h2);
        end
        checks++;
        if (bus.rs2_data !== 32'h2) begin
            failures++;
            $display("FAIL bypass_rs2 got=%h exp=%h", bus.rs2_data, 32'h2);
        end
        checks++;
        if (bus.dbg_data !== 32'h1) begin
            failures++;
            $display("FAIL bypass_dbg_old got=%h exp=%h", bus.dbg_data, 32'h1);
        end
        bus.rs2_addr = 5'd5;
        #1;
        checks++;
        if (bus.rs2_data !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL bypass_other_addr got=%h exp=%h", bus.rs2_data, 32'hDEADBEEF);
        end
        tick();
        bus.reg_write = 1'b0;
        #1;
        checks++;
        if (bus.dbg_data !== 32'h2) begin
            failures++;
            $display("FAIL bypass_dbg_new got=%h exp=%h", bus.dbg_data, 32'h2);
        end
        checks++;
        if (bus.wr_count !== 16'd3) begin
            failures++;
            $display("FAIL bypass_count got=%0d exp=%0d", bus.wr_count, 3);
        end
    endtask

    task automatic test_x_safety();
        bus.reg_write = 1'b0;
        bus.rd_addr   = 5'd5;
        bus.wr_data   = 32'h0BADF00D;
        bus.rs1_addr  = 5'd5;
        #1;
        checks++;
        if (bus.rs1_data !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL xsafe_no_bypass got=%h exp=%h", bus.rs1_data, 32'hDEADBEEF);
        end
        tick();
        bus.rd_addr = 'x;
        bus.wr_data = 'x;
        tick();
        checks++;
        if (bus.rs1_data !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL xsafe_hold got=%h exp=%h", bus.rs1_data, 32'hDEADBEEF);
        end
        checks++;
        if (bus.wr_count !== 16'd3) begin
            failures++;
            $display("FAIL xsafe_count got=%0d exp=%0d", bus.wr_count, 3);
        end
    endtask

    task automatic test_reset_mid_write();
        bus.rd_addr   = 5'd3;
        bus.wr_data   = 32'hA5A5A5A5;
        bus.reg_write = 1'b1;
        tick();
        rst          = 1'b1;
        bus.wr_data  = 32'h12345678;
        bus.rs1_addr = 5'd3;
        #1;
        checks++;
        if (bus.rs1_data !== 32'hA5A5A5A5) begin
            failures++;
            $display("FAIL rstmid_no_bypass got=%h exp=%h", bus.rs1_data, 32'hA5A5A5A5);
        end
        tick();
        rst           = 1'b0;
        bus.reg_write = 1'b0;
        bus.rs2_addr  = 5'd9;
        bus.dbg_addr  = 5'd5;
        #1;
        checks++;
        if (bus.rs1_data !== 32'h0) begin
            failures++;
            $display("FAIL rstmid_reg3 got=%h exp=%h", bus.rs1_data, 32'h0);
        end
        checks++;
        if (bus.rs2_data !== 32'h0) begin
            failures++;
            $display("FAIL rstmid_reg9 got=%h exp=%h", bus.rs2_data, 32'h0);
        end
        checks++;
        if (bus.dbg_data !== 32'h0) begin
            failures++;
            $display("FAIL rstmid_reg5 got=%h exp=%h", bus.dbg_data, 32'h0);
        end
        checks++;
        if (bus.wr_count !== 16'd0) begin
            failures++;
            $display("FAIL rstmid_count got=%0d exp=%0d", bus.wr_count, 0);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] vals [3];
        vals[0] = 32'h11111111;
        vals[1] = 32'h22222222;
        vals[2] = 32'h33333333;
        bus.rd_addr   = 5'd7;
        bus.rs1_addr  = 5'd7;
        bus.dbg_addr  = 5'd7;
        bus.reg_write = 1'b1;
        for (int k = 0; k < 3; k++) begin
            bus.wr_data = vals[k];
            #1;
            checks++;
            if (bus.rs1_data !== vals[k]) begin
                failures++;
                $display("FAIL b2b_bypass[%0d] got=%h exp=%h", k, bus.rs1_data, vals[k]);
            end
            tick();
        end
        bus.reg_write = 1'b0;
        #1;
        checks++;
        if (bus.dbg_data !== 32'h33333333) begin
            failures++;
            $display("FAIL b2b_last got=%h exp=%h", bus.dbg_data, 32'h33333333);
        end
        checks++;
        if (bus.wr_count !== 16'd3) begin
            failures++;
            $display("FAIL b2b_count got=%0d exp=%0d", bus.wr_count, 3);
        end
    endtask

    task automatic test_saturation();
        logic [31:0] exp_reg [32];
        logic [4:0]  rd;
        logic [31:0] data;
        rst           = 1'b1;
        bus.reg_write = 1'b0;
        tick();
        rst = 1'b0;
        for (int r = 0; r < 32; r++) exp_reg[r] = 32'h0;
        bus.reg_write = 1'b1;
        for (int n = 0; n < 65540; n++) begin
            rd          = 5'((n % 31) + 1);
            data        = 32'(n) ^ 32'hC0DE0000;
            bus.rd_addr = rd;
            bus.wr_data = data;
            exp_reg[rd] = data;
            tick();
            if (n == 9) begin
                checks++;
                if (bus.wr_count !== 16'd10) begin
                    failures++;
                    $display("FAIL sat_count_early got=%0d exp=%0d", bus.wr_count, 10);
                end
            end
            if (n == 65533) begin
                checks++;
                if (bus.wr_count !== 16'hFFFE) begin
                    failures++;
                    $display("FAIL sat_count_pre got=%h exp=%h", bus.wr_count, 16'hFFFE);
                end
            end
        end
        bus.reg_write = 1'b0;
        #1;
        checks++;
        if (bus.wr_count !== 16'hFFFF) begin
            failures++;
            $display("FAIL sat_count_final got=%h exp=%h", bus.wr_count, 16'hFFFF);
        end
        for (int r = 1; r < 32; r++) begin
            bus.dbg_addr = 5'(r);
            bus.rs2_addr = 5'(r);
            #1;
            checks++;
            if (bus.dbg_data !== exp_reg[r] || bus.rs2_data !== exp_reg[r]) begin
                failures++;
                $display("FAIL sat_reg[%0d] dbg=%h rs2=%h exp=%h",
                         r, bus.dbg_data, bus.rs2_data, exp_reg[r]);
            end
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_basic_write();
        test_x0();
        test_bypass();
        test_x_safety();
        test_reset_mid_write();
        test_back_to_back();
        test_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
